// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types, constants and the round-robin pick helper for
//                the memory port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Per-path transaction state: waiting for a request, forwarding the
    // request downstream, waiting for the downstream reply.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } path_state_e;

    // Width of the read/write response code.
    localparam int RESP_W = 2;

    // Largest master count the pick helper can search; callers zero-extend
    // their valid vector to this width.
    localparam int MAX_PORTS = 32;
    localparam int MAX_IDX_W = $clog2(MAX_PORTS);

    // Returns the first set index of valid, searching ptr, ptr+1, ... and
    // wrapping modulo num_ports. Returns ptr when nothing is set. Callers
    // truncate the result to their own $clog2(NUM_PORTS) index width.
    function automatic int unsigned rr_pick(
        input logic [MAX_PORTS-1:0] valid,
        input int unsigned          ptr,
        input int unsigned          num_ports
    );
        int unsigned idx;
        logic        found;
        found   = 1'b0;
        rr_pick = ptr;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            idx = ptr + i;
            if (idx >= num_ports) begin
                idx = idx - num_ports;
            end
            if (!found && (i < num_ports) && valid[idx[MAX_IDX_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_path.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_path
//  Description : One arbitration path (read or write). Round-robin grant of
//                a single outstanding transaction, request payload mux and
//                reply valid/ready routing back to the granted master.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_path
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PAYLOAD_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_valid_i,
    output logic [NUM_PORTS-1:0]           req_ready_o,
    input  logic [NUM_PORTS*PAYLOAD_W-1:0] req_payload_i,
    output logic [NUM_PORTS-1:0]           rep_valid_o,
    input  logic [NUM_PORTS-1:0]           rep_ready_i,
    output logic                           dn_req_valid_o,
    input  logic                           dn_req_ready_i,
    output logic [PAYLOAD_W-1:0]           dn_req_payload_o,
    input  logic                           dn_rep_valid_i,
    output logic                           dn_rep_ready_o
);

    localparam int                IDX_W    = $clog2(NUM_PORTS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PORTS - 1);

    path_state_e      state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;

    // The granted master's payload is forwarded without a register stage.
    assign dn_req_payload_o = req_payload_i[grant_q*PAYLOAD_W +: PAYLOAD_W];

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic and handshake routing; only the granted master ever
    // sees ready or reply valid, and only in the matching phase.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        req_ready_o    = '0;
        rep_valid_o    = '0;
        dn_req_valid_o = 1'b0;
        dn_rep_ready_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    grant_d = IDX_W'(rr_pick(MAX_PORTS'(req_valid_i), 32'(ptr_q), NUM_PORTS));
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                dn_req_valid_o       = 1'b1;
                req_ready_o[grant_q] = dn_req_ready_i;
                if (dn_req_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rep_valid_o[grant_q] = dn_rep_valid_i;
                dn_rep_ready_o       = rep_ready_i[grant_q];
                // The pointer moves past the winner only once its reply lands.
                if (dn_rep_valid_i && rep_ready_i[grant_q]) begin
                    ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : N-to-1 memory arbiter with independent read and write paths.
//                This level only packs/unpacks per-master payloads; the
//                arbitration lives in mem_arb_path.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    // upstream read channel
    input  logic [NUM_PORTS-1:0]              up_r_request_valid_i,
    output logic [NUM_PORTS-1:0]              up_r_request_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   up_r_request_raddr_i,
    output logic [NUM_PORTS-1:0]              up_r_reply_valid_o,
    input  logic [NUM_PORTS-1:0]              up_r_reply_ready_i,
    output logic [DATA_WIDTH-1:0]             up_r_reply_rdata_o,
    output logic [RESP_W-1:0]                 up_r_reply_rresp_o,
    // upstream write channel
    input  logic [NUM_PORTS-1:0]              up_w_request_valid_i,
    output logic [NUM_PORTS-1:0]              up_w_request_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   up_w_request_waddr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   up_w_request_wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] up_w_request_wmask_i,
    output logic [NUM_PORTS-1:0]              up_w_reply_valid_o,
    input  logic [NUM_PORTS-1:0]              up_w_reply_ready_i,
    output logic [RESP_W-1:0]                 up_w_reply_bresp_o,
    // downstream read channel
    output logic                              dn_r_request_valid_o,
    input  logic                              dn_r_request_ready_i,
    output logic [ADDR_WIDTH-1:0]             dn_r_request_raddr_o,
    input  logic                              dn_r_reply_valid_i,
    output logic                              dn_r_reply_ready_o,
    input  logic [DATA_WIDTH-1:0]             dn_r_reply_rdata_i,
    input  logic [RESP_W-1:0]                 dn_r_reply_rresp_i,
    // downstream write channel
    output logic                              dn_w_request_valid_o,
    input  logic                              dn_w_request_ready_i,
    output logic [ADDR_WIDTH-1:0]             dn_w_request_waddr_o,
    output logic [DATA_WIDTH-1:0]             dn_w_request_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           dn_w_request_wmask_o,
    input  logic                              dn_w_reply_valid_i,
    output logic                              dn_w_reply_ready_o,
    input  logic [RESP_W-1:0]                 dn_w_reply_bresp_i
);

    localparam int MASK_W = DATA_WIDTH / 8;
    localparam int WR_PW  = ADDR_WIDTH + DATA_WIDTH + MASK_W;

    logic [NUM_PORTS*WR_PW-1:0] w_wr_payload;
    logic [WR_PW-1:0]           w_dn_wr_payload;

    // Write payload per master is addr|data|mask, MSB first.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wr_pack
        assign w_wr_payload[i*WR_PW +: WR_PW] = {
            up_w_request_waddr_i[i*ADDR_WIDTH +: ADDR_WIDTH],
            up_w_request_wdata_i[i*DATA_WIDTH +: DATA_WIDTH],
            up_w_request_wmask_i[i*MASK_W     +: MASK_W]
        };
    end

    assign {dn_w_request_waddr_o, dn_w_request_wdata_o, dn_w_request_wmask_o} = w_dn_wr_payload;

    // Reply payloads are shared; only the owning master's valid qualifies them.
    assign up_r_reply_rdata_o = dn_r_reply_rdata_i;
    assign up_r_reply_rresp_o = dn_r_reply_rresp_i;
    assign up_w_reply_bresp_o = dn_w_reply_bresp_i;

    mem_arb_path #(
        .NUM_PORTS (NUM_PORTS),
        .PAYLOAD_W (ADDR_WIDTH)
    ) u_rd_path (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (up_r_request_valid_i),
        .req_ready_o      (up_r_request_ready_o),
        .req_payload_i    (up_r_request_raddr_i),
        .rep_valid_o      (up_r_reply_valid_o),
        .rep_ready_i      (up_r_reply_ready_i),
        .dn_req_valid_o   (dn_r_request_valid_o),
        .dn_req_ready_i   (dn_r_request_ready_i),
        .dn_req_payload_o (dn_r_request_raddr_o),
        .dn_rep_valid_i   (dn_r_reply_valid_i),
        .dn_rep_ready_o   (dn_r_reply_ready_o)
    );

    mem_arb_path #(
        .NUM_PORTS (NUM_PORTS),
        .PAYLOAD_W (WR_PW)
    ) u_wr_path (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (up_w_request_valid_i),
        .req_ready_o      (up_w_request_ready_o),
        .req_payload_i    (w_wr_payload),
        .rep_valid_o      (up_w_reply_valid_o),
        .rep_ready_i      (up_w_reply_ready_i),
        .dn_req_valid_o   (dn_w_request_valid_o),
        .dn_req_ready_i   (dn_w_request_ready_i),
        .dn_req_payload_o (w_dn_wr_payload),
        .dn_rep_valid_i   (dn_w_reply_valid_i),
        .dn_rep_ready_o   (dn_w_reply_ready_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with three masters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int MW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    up_r_request_valid, up_r_request_ready, up_r_reply_valid, up_r_reply_ready;
    logic [N*AW-1:0] up_r_request_raddr;
    logic [DW-1:0]   up_r_reply_rdata;
    logic [1:0]      up_r_reply_rresp;
    logic [N-1:0]    up_w_request_valid, up_w_request_ready, up_w_reply_valid, up_w_reply_ready;
    logic [N*AW-1:0] up_w_request_waddr;
    logic [N*DW-1:0] up_w_request_wdata;
    logic [N*MW-1:0] up_w_request_wmask;
    logic [1:0]      up_w_reply_bresp;
    logic            dn_r_request_valid, dn_r_request_ready, dn_r_reply_valid, dn_r_reply_ready;
    logic [AW-1:0]   dn_r_request_raddr;
    logic [DW-1:0]   dn_r_reply_rdata;
    logic [1:0]      dn_r_reply_rresp;
    logic            dn_w_request_valid, dn_w_request_ready, dn_w_reply_valid, dn_w_reply_ready;
    logic [AW-1:0]   dn_w_request_waddr;
    logic [DW-1:0]   dn_w_request_wdata;
    logic [MW-1:0]   dn_w_request_wmask;
    logic [1:0]      dn_w_reply_bresp;

    mem_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .up_r_request_valid_i(up_r_request_valid), .up_r_request_ready_o(up_r_request_ready),
        .up_r_request_raddr_i(up_r_request_raddr), .up_r_reply_valid_o(up_r_reply_valid),
        .up_r_reply_ready_i(up_r_reply_ready), .up_r_reply_rdata_o(up_r_reply_rdata),
        .up_r_reply_rresp_o(up_r_reply_rresp),
        .up_w_request_valid_i(up_w_request_valid), .up_w_request_ready_o(up_w_request_ready),
        .up_w_request_waddr_i(up_w_request_waddr), .up_w_request_wdata_i(up_w_request_wdata),
        .up_w_request_wmask_i(up_w_request_wmask), .up_w_reply_valid_o(up_w_reply_valid),
        .up_w_reply_ready_i(up_w_reply_ready), .up_w_reply_bresp_o(up_w_reply_bresp),
        .dn_r_request_valid_o(dn_r_request_valid), .dn_r_request_ready_i(dn_r_request_ready),
        .dn_r_request_raddr_o(dn_r_request_raddr), .dn_r_reply_valid_i(dn_r_reply_valid),
        .dn_r_reply_ready_o(dn_r_reply_ready), .dn_r_reply_rdata_i(dn_r_reply_rdata),
        .dn_r_reply_rresp_i(dn_r_reply_rresp),
        .dn_w_request_valid_o(dn_w_request_valid), .dn_w_request_ready_i(dn_w_request_ready),
        .dn_w_request_waddr_o(dn_w_request_waddr), .dn_w_request_wdata_o(dn_w_request_wdata),
        .dn_w_request_wmask_o(dn_w_request_wmask), .dn_w_reply_valid_i(dn_w_reply_valid),
        .dn_w_reply_ready_o(dn_w_reply_ready), .dn_w_reply_bresp_i(dn_w_reply_bresp)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Path-neutral views so the same sequences drive either the read or write path.
    bit            wr_sel = 1'b0;
    logic [N-1:0]  v_up_rdy, v_rep_v;
    logic          v_dn_v, v_dn_rep_rdy;
    logic [AW-1:0] v_dn_addr;
    logic [DW-1:0] v_dn_wdata, v_rep_data;
    logic [MW-1:0] v_dn_mask;
    logic [1:0]    v_rep_resp;
    assign v_up_rdy     = wr_sel ? up_w_request_ready : up_r_request_ready;
    assign v_rep_v      = wr_sel ? up_w_reply_valid   : up_r_reply_valid;
    assign v_dn_v       = wr_sel ? dn_w_request_valid : dn_r_request_valid;
    assign v_dn_rep_rdy = wr_sel ? dn_w_reply_ready   : dn_r_reply_ready;
    assign v_dn_addr    = wr_sel ? dn_w_request_waddr : dn_r_request_raddr;
    assign v_dn_wdata   = wr_sel ? dn_w_request_wdata : '0;
    assign v_dn_mask    = wr_sel ? dn_w_request_wmask : '0;
    assign v_rep_data   = wr_sel ? '0 : up_r_reply_rdata;
    assign v_rep_resp   = wr_sel ? up_w_reply_bresp : up_r_reply_rresp;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int m);
        oh = '0;
        if (m >= 0 && m < N) oh[m] = 1'b1;
    endfunction

    // Round-robin rule: first requester at ptr, ptr+1, ... modulo N; -1 if none.
    function automatic int rr_ref(input logic [N-1:0] req, input int ptr);
        rr_ref = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(ptr + k) % N]) rr_ref = (ptr + k) % N;
        end
    endfunction

    task automatic set_req(input bit wr, input int m, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [MW-1:0] mk);
        if (wr) begin
            up_w_request_valid[m]         = v;
            up_w_request_waddr[m*AW +: AW] = a;
            up_w_request_wdata[m*DW +: DW] = d;
            up_w_request_wmask[m*MW +: MW] = mk;
        end else begin
            up_r_request_valid[m]         = v;
            up_r_request_raddr[m*AW +: AW] = a;
        end
    endtask

    task automatic set_dn_rdy(input bit wr, input logic v);
        if (wr) dn_w_request_ready = v; else dn_r_request_ready = v;
    endtask

    task automatic set_dn_rep(input bit wr, input logic v, input logic [DW-1:0] d, input logic [1:0] r);
        if (wr) begin
            dn_w_reply_valid = v; dn_w_reply_bresp = r;
        end else begin
            dn_r_reply_valid = v; dn_r_reply_rdata = d; dn_r_reply_rresp = r;
        end
    endtask

    task automatic set_up_rep_rdy(input bit wr, input logic [N-1:0] v);
        if (wr) up_w_reply_ready = v; else up_r_reply_ready = v;
    endtask

    task automatic clear_inputs();
        up_r_request_valid = '0; up_r_request_raddr = '0; up_r_reply_ready = '0;
        up_w_request_valid = '0; up_w_request_waddr = '0; up_w_request_wdata = '0;
        up_w_request_wmask = '0; up_w_reply_ready = '0;
        dn_r_request_ready = 1'b0; dn_r_reply_valid = 1'b0; dn_r_reply_rdata = '0; dn_r_reply_rresp = '0;
        dn_w_request_ready = 1'b0; dn_w_reply_valid = 1'b0; dn_w_reply_bresp = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_up_r_rdy"}, up_r_request_ready, '0);
        chk({tag, "_up_r_repv"}, up_r_reply_valid, '0);
        chk({tag, "_up_w_rdy"}, up_w_request_ready, '0);
        chk({tag, "_up_w_repv"}, up_w_reply_valid, '0);
        chk({tag, "_dn_r_v"}, dn_r_request_valid, '0);
        chk({tag, "_dn_r_reprdy"}, dn_r_reply_ready, '0);
        chk({tag, "_dn_w_v"}, dn_w_request_valid, '0);
        chk({tag, "_dn_w_reprdy"}, dn_w_reply_ready, '0);
    endtask

    // Always-ready slave serving one transaction for master m; the master then
    // either drops valid or keeps requesting with next_a. Entered and left at
    // posedge+1, leaving the path in IDLE.
    task automatic serve_one(input bit wr, input int m, input logic [AW-1:0] a,
                             input logic keep, input logic [AW-1:0] next_a, input string tag);
        bit seen;
        seen   = 1'b0;
        wr_sel = wr;
        set_dn_rdy(wr, 1'b1);
        for (int c = 0; c < 12 && !seen; c++) begin
            #4;
            if (v_dn_v === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk({tag, "_req_seen"}, seen, 1);
        chk({tag, "_addr"}, v_dn_addr, a);
        chk({tag, "_grant"}, v_up_rdy, oh(m));
        @(posedge clk); #1;
        set_req(wr, m, keep, next_a, '0, '0);
        set_dn_rdy(wr, 1'b0);
        set_dn_rep(wr, 1'b1, {4{32'hC0DE_0000 + a}}, 2'b00);
        set_up_rep_rdy(wr, '1);
        #4;
        chk({tag, "_rep_route"}, v_rep_v, oh(m));
        @(posedge clk); #1;
        set_dn_rep(wr, 1'b0, '0, '0);
        set_up_rep_rdy(wr, '0);
    endtask

    typedef struct {
        bit            wr;
        int            m;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;      // wdata for writes, downstream rdata for reads
        logic [MW-1:0] mask;
        logic [1:0]    resp;
        int            req_wait;  // cycles dn request ready is held low
        int            rep_hold;  // cycles the reply is held with up reply ready low
        logic [N-1:0]  exp_vec;   // required one-hot ready / reply valid
    } vec_t;

    task automatic run_vec(input vec_t t, input int idx);
        string tag;
        tag    = $sformatf("vec%0d", idx);
        wr_sel = t.wr;
        set_req(t.wr, t.m, 1'b1, t.addr, t.data, t.mask);
        set_dn_rdy(t.wr, 1'b0);
        set_dn_rep(t.wr, 1'b0, '0, '0);
        set_up_rep_rdy(t.wr, '0);
        #4;
        chk({tag, "_c0_rdy"}, v_up_rdy, '0);
        chk({tag, "_c0_dnv"}, v_dn_v, 0);
        @(posedge clk); #1;
        for (int w = 0; w < t.req_wait; w++) begin
            #4;
            chk({tag, "_wait_dnv"}, v_dn_v, 1);
            chk({tag, "_wait_addr"}, v_dn_addr, t.addr);
            chk({tag, "_wait_rdy"}, v_up_rdy, '0);
            @(posedge clk); #1;
        end
        set_dn_rdy(t.wr, 1'b1);
        #4;
        chk({tag, "_dnv"}, v_dn_v, 1);
        chk({tag, "_addr"}, v_dn_addr, t.addr);
        if (t.wr) begin
            chk({tag, "_wdata"}, v_dn_wdata, t.data);
            chk({tag, "_wmask"}, v_dn_mask, t.mask);
        end
        chk({tag, "_rdy"}, v_up_rdy, t.exp_vec);
        @(posedge clk); #1;
        set_req(t.wr, t.m, 1'b0, t.addr, t.data, t.mask);
        set_dn_rdy(t.wr, 1'b0);
        set_dn_rep(t.wr, 1'b1, t.data, t.resp);
        for (int h = 0; h < t.rep_hold; h++) begin
            #4;
            chk({tag, "_hold_repv"}, v_rep_v, t.exp_vec);
            chk({tag, "_hold_dnrdy"}, v_dn_rep_rdy, 0);
            @(posedge clk); #1;
        end
        set_up_rep_rdy(t.wr, t.exp_vec);
        #4;
        chk({tag, "_repv"}, v_rep_v, t.exp_vec);
        chk({tag, "_resp"}, v_rep_resp, t.resp);
        if (!t.wr) chk({tag, "_rdata"}, v_rep_data, t.data);
        chk({tag, "_dnrdy"}, v_dn_rep_rdy, 1);
        @(posedge clk); #1;
        set_dn_rep(t.wr, 1'b0, '0, '0);
        set_up_rep_rdy(t.wr, '0);
        #4;
        chk({tag, "_idle_dnv"}, v_dn_v, 0);
        chk({tag, "_idle_repv"}, v_rep_v, '0);
        @(posedge clk); #1;
    endtask

    // Random traffic on one path against the round-robin reference rule.
    task automatic rand_run(input bit wr, input int ncyc);
        logic [N-1:0]  pend, drv, urdy;
        logic [AW-1:0] addr [N];
        logic [DW-1:0] wd [N];
        logic [MW-1:0] mk [N];
        logic [DW-1:0] rd;
        logic [1:0]    rr;
        logic          dr, prev_dnv;
        logic [N-1:0]  prev_drv;
        bit            outst, shown;
        int            ptr, exp_m, done, stall;
        string         tag;
        tag = wr ? "rndw" : "rndr";
        pend = '0; prev_drv = '0; prev_dnv = 1'b0; outst = 0; shown = 0;
        ptr = 0; exp_m = -1; done = 0; stall = 0; rd = '0; rr = '0;
        for (int m = 0; m < N; m++) begin addr[m] = '0; wd[m] = '0; mk[m] = '0; end
        wr_sel = wr;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int m = 0; m < N; m++) begin
                if (!pend[m] && $urandom_range(2) == 0) begin
                    pend[m] = 1'b1;
                    addr[m] = $urandom;
                    wd[m]   = {$urandom, $urandom, $urandom, $urandom};
                    mk[m]   = MW'($urandom);
                end
                set_req(wr, m, pend[m], addr[m], wd[m], mk[m]);
            end
            drv = pend;
            dr  = 1'($urandom_range(1));
            set_dn_rdy(wr, dr);
            if (outst && !shown && $urandom_range(1) == 1) begin
                shown = 1;
                rd    = {$urandom, $urandom, $urandom, $urandom};
                rr    = 2'($urandom);
            end
            set_dn_rep(wr, shown, rd, rr);
            urdy = N'($urandom);
            set_up_rep_rdy(wr, urdy);
            #4;
            if (v_dn_v === 1'b1 && prev_dnv !== 1'b1) begin
                exp_m = rr_ref(prev_drv, ptr);
                chk({tag, "_grant_exists"}, (exp_m >= 0), 1);
            end
            if (v_dn_v === 1'b1 && exp_m >= 0) begin
                chk({tag, "_addr"}, v_dn_addr, addr[exp_m]);
                if (wr) begin
                    chk({tag, "_wdata"}, v_dn_wdata, wd[exp_m]);
                    chk({tag, "_wmask"}, v_dn_mask, mk[exp_m]);
                end
                chk({tag, "_rdy"}, v_up_rdy, dr ? oh(exp_m) : '0);
            end else begin
                chk({tag, "_rdy_idle"}, v_up_rdy, '0);
            end
            if (shown && exp_m >= 0) begin
                chk({tag, "_repv"}, v_rep_v, oh(exp_m));
                chk({tag, "_resp"}, v_rep_resp, rr);
                if (!wr) chk({tag, "_rdata"}, v_rep_data, rd);
                chk({tag, "_dnrdy"}, v_dn_rep_rdy, urdy[exp_m]);
            end else begin
                chk({tag, "_repv_none"}, v_rep_v, '0);
            end
            if (!outst) chk({tag, "_dnrdy_out_of_resp"}, v_dn_rep_rdy, 0);
            stall++;
            if (v_dn_v === 1'b1 && dr && exp_m >= 0) begin
                pend[exp_m] = 1'b0;
                outst       = 1;
                stall       = 0;
            end
            if (shown && exp_m >= 0 && urdy[exp_m]) begin
                outst = 0;
                shown = 0;
                ptr   = (exp_m + 1) % N;
                done++;
                stall = 0;
            end
            prev_dnv = v_dn_v;
            prev_drv = drv;
            if (stall > 60) begin
                chk({tag, "_progress_timeout"}, 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_enough_done"}, (done >= 20), 1);
    endtask

    vec_t tbl [5];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b0, 1, 32'h0000_0100, {4{32'hDEAD_BEEF}}, 16'h0000, 2'b00, 0, 0, 3'b010};
        tbl[1] = '{1'b1, 2, 32'h0000_2000, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 16'hF0F0, 2'b01, 1, 0, 3'b100};
        tbl[2] = '{1'b0, 0, 32'h0000_0300, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 16'h0000, 2'b10, 5, 3, 3'b001};
        tbl[3] = '{1'b1, 0, 32'h0000_0080, {4{32'hA5A5_5A5A}}, 16'hFFFF, 2'b00, 2, 2, 3'b001};
        tbl[4] = '{1'b0, 2, 32'hFFFF_FFF0, {4{32'h0BAD_F00D}}, 16'h0000, 2'b11, 0, 1, 3'b100};

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        check_all_zero("reset");
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

        // Read from master 0 and write from master 1 in the same cycle.
        set_req(1'b0, 0, 1'b1, 32'h40, '0, '0);
        set_req(1'b1, 1, 1'b1, 32'h80, {4{32'h1357_9BDF}}, 16'hFFFF);
        dn_r_request_ready = 1'b1;
        dn_w_request_ready = 1'b1;
        @(posedge clk); #1;
        #4;
        chk("par_dn_r_v", dn_r_request_valid, 1);
        chk("par_dn_w_v", dn_w_request_valid, 1);
        chk("par_raddr", dn_r_request_raddr, 32'h40);
        chk("par_waddr", dn_w_request_waddr, 32'h80);
        chk("par_wmask", dn_w_request_wmask, 16'hFFFF);
        chk("par_r_rdy", up_r_request_ready, 3'b001);
        chk("par_w_rdy", up_w_request_ready, 3'b010);
        @(posedge clk); #1;
        clear_inputs();
        set_dn_rep(1'b0, 1'b1, {4{32'h7777_0040}}, 2'b00);
        set_dn_rep(1'b1, 1'b1, '0, 2'b01);
        up_r_reply_ready = '1;
        up_w_reply_ready = '1;
        #4;
        chk("par_r_repv", up_r_reply_valid, 3'b001);
        chk("par_w_repv", up_w_reply_valid, 3'b010);
        chk("par_rdata", up_r_reply_rdata, {4{32'h7777_0040}});
        chk("par_bresp", up_w_reply_bresp, 2'b01);
        @(posedge clk); #1;
        clear_inputs();

        // Contention from a fresh reset: both masters request continuously.
        apply_reset();
        set_req(1'b0, 0, 1'b1, 32'h1000, '0, '0);
        set_req(1'b0, 1, 1'b1, 32'h2000, '0, '0);
        serve_one(1'b0, 0, 32'h1000, 1'b1, 32'h1010, "cont0");
        serve_one(1'b0, 1, 32'h2000, 1'b1, 32'h2010, "cont1");
        serve_one(1'b0, 0, 32'h1010, 1'b0, 32'h1010, "cont2");
        serve_one(1'b0, 1, 32'h2010, 1'b0, 32'h2010, "cont3");

        // Reset in RESP with the pointer at 1 must return it to 0.
        set_req(1'b0, 0, 1'b1, 32'h500, '0, '0);
        serve_one(1'b0, 0, 32'h500, 1'b1, 32'h504, "rstpre");
        set_dn_rdy(1'b0, 1'b1);
        @(posedge clk); #1;
        #4;
        chk("rst_req_dnv", dn_r_request_valid, 1);
        @(posedge clk); #1;
        set_req(1'b0, 0, 1'b0, 32'h504, '0, '0);
        set_dn_rdy(1'b0, 1'b0);
        set_dn_rep(1'b0, 1'b1, '1, 2'b00);
        rst = 1'b1;
        #4;
        chk("rst_resp_repv", up_r_reply_valid, 3'b001);
        @(posedge clk); #1;
        rst = 1'b0;
        #4;
        check_all_zero("rst_mid_resp");
        @(posedge clk); #1;
        set_dn_rep(1'b0, 1'b0, '0, '0);
        set_req(1'b0, 0, 1'b1, 32'h600, '0, '0);
        set_req(1'b0, 1, 1'b1, 32'h700, '0, '0);
        serve_one(1'b0, 0, 32'h600, 1'b0, 32'h600, "rstpost0");
        serve_one(1'b0, 1, 32'h700, 1'b0, 32'h700, "rstpost1");

        // Wrap: p=2 with masters 0 and 2 requesting, on the write path.
        apply_reset();
        set_req(1'b1, 1, 1'b1, 32'h111, '0, '0);
        serve_one(1'b1, 1, 32'h111, 1'b0, 32'h111, "wrap_p2");
        set_req(1'b1, 0, 1'b1, 32'hA0, '0, '0);
        set_req(1'b1, 2, 1'b1, 32'hC0, '0, '0);
        serve_one(1'b1, 2, 32'hC0, 1'b0, 32'hC0, "wrap_m2");
        serve_one(1'b1, 0, 32'hA0, 1'b0, 32'hA0, "wrap_m0");
        set_req(1'b1, 1, 1'b1, 32'hB1, '0, '0);
        set_req(1'b1, 2, 1'b1, 32'hC1, '0, '0);
        serve_one(1'b1, 1, 32'hB1, 1'b0, 32'hB1, "wrap_p1");
        serve_one(1'b1, 2, 32'hC1, 1'b0, 32'hC1, "wrap_tail");

        apply_reset();
        rand_run(1'b0, 400);
        apply_reset();
        rand_run(1'b1, 400);
        apply_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised N-to-1 memory arbiter that lets several upstream masters (I-cache, D-cache, further agents) share one downstream memory port carrying the team's split read/write request/reply channels. Read and write paths are arbitrated independently with round-robin fairness and one outstanding transaction per path. Replies are routed back to the owning master. The block sits between the L1 caches and the main-memory slave.

## Interface

- NUM_PORTS, 2, number of upstream masters (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 128, data width; mask width is DATA_WIDTH/8
- clk  in  1  clock; the only clock
- rst  in  1  reset, synchronous, active-high
- up_r_request_valid / _ready  in / out  NUM_PORTS  per-master read request handshake
- up_r_request_raddr  in  NUM_PORTS×ADDR_WIDTH  per-master read address
- up_r_reply_valid / _ready  out / in  NUM_PORTS  per-master read reply handshake
- up_r_reply_rdata  out  DATA_WIDTH  shared read data, meaningful only with the owning valid
- up_r_reply_rresp  out  2  shared read response
- up_w_request_valid / _ready  in / out  NUM_PORTS  per-master write request handshake
- up_w_request_waddr / _wdata / _wmask  in  NUM_PORTS×(ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8)  per-master write payload
- up_w_reply_valid / _ready  out / in  NUM_PORTS  per-master write reply handshake
- up_w_reply_bresp  out  2  shared write response
- dn_r_request_valid/_ready, dn_r_request_raddr, dn_r_reply_valid/_ready, dn_r_reply_rdata, dn_r_reply_rresp: downstream read channel, mirrored directions
- dn_w_request_valid/_ready, dn_w_request_waddr/_wdata/_wmask, dn_w_reply_valid/_ready, dn_w_reply_bresp: downstream write channel, mirrored directions

## Operation

- A transfer occurs on any channel in a cycle where valid and ready are both 1. A master holds valid and its payload stable until the handshake.
- Each path (read, write) runs its own FSM with states IDLE, REQ and RESP, a registered grant index g, and a round-robin pointer p.
- IDLE:
  - If any up request valid is set, g is registered to the first valid index searching p, p+1, …, wrapping mod NUM_PORTS.
  - The FSM then moves to REQ.
  - In IDLE, all up ready and reply valid outputs are 0.
- REQ:
  - dn request valid is 1, and the dn payload is taken from master g.
  - Up request ready[g] equals dn request ready; all other up request ready outputs are 0.
  - On the dn handshake, the FSM moves to RESP.
- RESP:
  - Up reply valid[g] equals dn reply valid, and the reply payload is passed through.
  - Dn reply ready equals up reply ready[g].
  - On the handshake, p becomes (g+1) mod NUM_PORTS and the FSM moves to IDLE.
- Non-granted masters see ready=0 and reply valid=0 at all times.
- Read and write paths never interact. A master may have one read and one write in flight simultaneously. Ordering between read and write is not guaranteed.
- Downstream replies arriving in IDLE or REQ are not accepted: dn reply ready is 0 outside RESP.

## Timing

- Reset: both FSMs go to IDLE, g=0, p=0. Every valid/ready output is 0 in the cycle after rst is sampled high. An in-flight transaction is dropped silently, and the downstream slave must be reset with it.
- Minimum latency: up valid is seen in cycle 0, dn valid is asserted in cycle 1. If dn ready=1 in cycle 1, the FSM is in RESP in cycle 2. A dn reply in cycle 2 is presented upstream combinationally in cycle 2. The FSM returns to IDLE in cycle 3, so the next grant is registered in cycle 3.
- Throughput: one transaction per path per 3 cycles minimum.
- Request and reply payloads are combinational pass-through with no added register stage. The ready paths are combinational from dn to up.
- Fairness: with all NUM_PORTS continuously requesting, grants rotate 0,1,…,N-1,0. No master waits more than NUM_PORTS-1 transactions.
- Simultaneous new requests while in REQ or RESP are held off (ready=0) and considered at the next IDLE.

## Structure

- Shared package mem_arb_pkg holds:
  - the path-state enum (IDLE, REQ, RESP)
  - the resp_t width constant (2)
  - a round-robin pick function (valid vector, pointer → index), parametrised by NUM_PORTS via a localparam width of $clog2(NUM_PORTS)
- Sub-module mem_arb_path holds the FSM, g, p, the grant decode and the reply routing. It is parametrised on NUM_PORTS and a payload width, and is instantiated once for the read path and once for the write path. The write payload is concatenated addr|data|mask.
- The top level handles only packing and unpacking of the per-master payload arrays.

## Test plan

- Single read, NUM_PORTS=2: master 1 raddr=0x100, dn ready=1, reply rdata=0xDEAD…, rresp=0. Required: dn raddr=0x100 at cycle 1; up_r_reply_valid=2'b10 carrying 0xDEAD…; FSM back in IDLE at cycle 3.
- Contention: masters 0 and 1 both read continuously for 4 transactions. Required grant order 0,1,0,1; addresses on dn match the granted master.
- Backpressure: dn request ready held 0 for 5 cycles, then dn reply held 3 cycles with up reply ready=0. Required: payload stable, up request ready=0 until dn ready, no reply lost, p advances only after the reply handshake.
- Parallel paths: master 0 reads 0x40 while master 1 writes 0x80 (wmask=0xFFFF) in the same cycle. Required: both dn requests issue in cycle 1 and both replies are routed correctly.
- Reset mid-RESP: assert rst during a read's RESP. Required: all outputs 0 next cycle, p=0, and a subsequent request from master 1 is granted normally.
- Wrap, NUM_PORTS=3: with p=2 and masters 0 and 2 requesting, master 2 is granted first, then master 0, and p ends at 1.
